rng_coord_gen: RTL

//  Consumer stage directly downstream of random_mod. Turns the free-running 16-bit

---
 rtl/rng_coord_gen.sv | 93 +++++++++
 1 files changed

// File: rtl/rng_coord_gen.sv
// rng_coord_gen: rejection-sampled 2D point burst generator with FWFT output FIFO
//   clk, rst_n            clock, asynchronous active-low reset
//   rnd_data, rnd_valid   random word stream (only low COORD_W bits sampled)
//   start, num_points     burst request, accepted only in IDLE
//   out_x, out_y          FIFO head point
//   out_valid, out_ready  FIFO not empty / consumer pop
//   busy, done            FSM not idle / one-cycle burst-complete pulse
//   reject_cnt            saturating count of rejected samples
module rng_coord_gen #(
  parameter int COORD_W    = 8,
  parameter int X_LIMIT    = 200,
  parameter int Y_LIMIT    = 150,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        rnd_data,
  input  logic               rnd_valid,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_points,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [15:0]        reject_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, SAMPLE_X, SAMPLE_Y, WRITE, DONE} state_t;
  state_t state;
  logic [COORD_W-1:0] sample, x_reg, y_reg;
  logic [CNT_W-1:0] remaining;
  logic [2*COORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, push, pop, x_ok, y_ok, reject, unused_hi;
  assign sample = rnd_data[COORD_W-1:0];
  assign unused_hi = ^rnd_data;
  // widen before comparing so a limit of 2**COORD_W accepts every sample
  assign x_ok = 32'(sample) < X_LIMIT;
  assign y_ok = 32'(sample) < Y_LIMIT;
  assign reject = rnd_valid && ((state == SAMPLE_X && !x_ok) || (state == SAMPLE_Y && !y_ok));
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop = !empty && out_ready;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push = state == WRITE && (!full || pop);
  assign out_valid = !empty;
  assign {out_x, out_y} = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {x_reg, y_reg};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x_reg <= '0;
      y_reg <= '0;
      remaining <= '0;
      reject_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (reject && reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 16'd1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case (state)
        IDLE:
          if (start) begin
            remaining <= num_points;
            state <= num_points == '0 ? DONE : SAMPLE_X;
          end
        SAMPLE_X:
          if (rnd_valid && x_ok) begin
            x_reg <= sample;
            state <= SAMPLE_Y;
          end
        SAMPLE_Y:
          if (rnd_valid && y_ok) begin
            y_reg <= sample;
            state <= WRITE;
          end
        WRITE:
          if (push) begin
            remaining <= remaining - 1'b1;
            state <= remaining == CNT_W'(1) ? DONE : SAMPLE_X;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
